// File: rtl/alu_div_pkg.sv
// Shared types and constants for the sequential signed divider.
// Optional unsigned mode is enabled by defining ALU_DIV_UNSIGNED_EN.
package alu_div_pkg;

    localparam int unsigned WIDTH_DEFAULT = 8;

    // Truncated to the instance width where it is used.
    localparam logic [63:0] DIV_ZERO_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE,
        DIV,
        FIX
    } state_e;

endpackage

// File: rtl/alu_div_if.sv
// START/BUSY/DONE handshake and operand/result bus of the divider.
// Defining ALU_DIV_UNSIGNED_EN adds the signed_op select.
interface alu_div_if #(
    parameter int unsigned WIDTH = alu_div_pkg::WIDTH_DEFAULT
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef ALU_DIV_UNSIGNED_EN
    logic             signed_op;
`endif
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;
    logic             busy;
    logic             done;

    modport master (
        output start, dividend, divisor,
`ifdef ALU_DIV_UNSIGNED_EN
        output signed_op,
`endif
        input  quotient, remainder, div_by_zero, busy, done
    );

    modport slave (
        input  start, dividend, divisor,
`ifdef ALU_DIV_UNSIGNED_EN
        input  signed_op,
`endif
        output quotient, remainder, div_by_zero, busy, done
    );

endinterface

// File: rtl/alu_div_sign_mag.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix-up.
module div_sign_mag #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] in,
    input  logic         neg_en,
    output logic [W-1:0] out
);

    assign out = neg_en ? (~in + W'(1)) : in;

endmodule

// File: rtl/alu_div.sv
// Restoring shift-subtract signed divider, one quotient bit per clock.
// Define ALU_DIV_UNSIGNED_EN to add a per-operation signed/unsigned select.
module alu_div
    import alu_div_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
    input logic      clk,
    input logic      reset,
    alu_div_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned MW    = WIDTH + 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [MW-1:0]      dvs_q, dvs_d;
    logic               sq_q, sq_d;
    logic               sr_q, sr_d;
    logic [WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]   remainder_q, remainder_d;
    logic               dbz_q, dbz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               is_signed;
    logic               neg_dividend;
    logic               neg_divisor;
    logic [WIDTH-1:0]   dividend_mag;
    logic [WIDTH-1:0]   divisor_mag;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;
    logic [MW-1:0]      rem_sh;

`ifdef ALU_DIV_UNSIGNED_EN
    assign is_signed = bus.signed_op;
`else
    assign is_signed = 1'b1;
`endif

    assign neg_dividend = is_signed & bus.dividend[WIDTH-1];
    assign neg_divisor  = is_signed & bus.divisor[WIDTH-1];

    // A negated WIDTH-bit value read as unsigned is the exact magnitude, even for -2^(WIDTH-1).
    div_sign_mag #(.W(WIDTH)) u_abs_dividend (
        .in     (bus.dividend),
        .neg_en (neg_dividend),
        .out    (dividend_mag)
    );

    div_sign_mag #(.W(WIDTH)) u_abs_divisor (
        .in     (bus.divisor),
        .neg_en (neg_divisor),
        .out    (divisor_mag)
    );

    div_sign_mag #(.W(WIDTH)) u_fix_quo (
        .in     (quo_q),
        .neg_en (sq_q),
        .out    (quo_fixed)
    );

    div_sign_mag #(.W(WIDTH)) u_fix_rem (
        .in     (rem_q),
        .neg_en (sr_q),
        .out    (rem_fixed)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            sq_q        <= 1'b0;
            sr_q        <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            sq_q        <= sq_d;
            sr_q        <= sr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        sq_d        = sq_q;
        sr_d        = sr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        rem_sh      = {rem_q, quo_q[WIDTH-1]};

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.divisor == '0) begin
                        quotient_d  = WIDTH'(DIV_ZERO_QUOTIENT);
                        remainder_d = bus.dividend;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        quo_d   = dividend_mag;
                        dvs_d   = {1'b0, divisor_mag};
                        rem_d   = '0;
                        cnt_d   = '0;
                        sq_d    = neg_dividend ^ neg_divisor;
                        sr_d    = neg_dividend;
                        busy_d  = 1'b1;
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
                // Partial remainder stays below the divisor, so it always fits back in WIDTH bits.
                if (rem_sh >= dvs_q) begin
                    rem_d    = WIDTH'(rem_sh - dvs_q);
                    quo_d[0] = 1'b1;
                end else begin
                    rem_d = rem_sh[WIDTH-1:0];
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                quotient_d  = quo_fixed;
                remainder_d = rem_fixed;
                dbz_d       = 1'b0;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_alu_div.sv
// Scoreboard bench for alu_div: stimulus queues expected results, a monitor checks each DONE.
// Runs the unsigned-mode vectors when ALU_DIV_UNSIGNED_EN is defined.
module tb_alu_div;

    import alu_div_pkg::*;

    localparam int unsigned W = 8;

    typedef struct {
        string          name;
        logic [W-1:0]   q;
        logic [W-1:0]   r;
        logic           dbz;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    alu_div_if #(.WIDTH(W)) bus ();

    alu_div #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endfunction

    // Monitor: every DONE pops one expected result; a DONE with nothing pending is an error.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && bus.done === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 required no pending operation");
            end else begin
                e = exp_q.pop_front();
                check({e.name, "_quotient"}, 32'(bus.quotient), 32'(e.q));
                check({e.name, "_remainder"}, 32'(bus.remainder), 32'(e.r));
                check({e.name, "_div_by_zero"}, 32'(bus.div_by_zero), 32'(e.dbz));
            end
        end
    end

    // Called at a negedge; leaves at the negedge where DONE is seen (or the budget runs out).
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edbz, input int exp_lat, input int poke);
        int cyc      = 0;
        int busy_cnt = 0;
        bit seen     = 1'b0;
        exp_t e;
        e.name = name;
        e.q    = eq;
        e.r    = er;
        e.dbz  = edbz;
        exp_q.push_back(e);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
`ifdef ALU_DIV_UNSIGNED_EN
        bus.signed_op = s;
`endif
        while (!seen && cyc < 30) begin
            @(negedge clk);
            cyc++;
            bus.start = 1'b0;
            if (poke != 0 && cyc == poke) begin
                bus.start    = 1'b1;
                bus.dividend = 8'h10;
                bus.divisor  = 8'h03;
            end
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) seen = 1'b1;
        end
        check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    endtask

    initial begin
        reset        = 1'b0;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
`ifdef ALU_DIV_UNSIGNED_EN
        bus.signed_op = 1'b1;
`endif
        repeat (2) @(negedge clk);
        check("reset_quotient", 32'(bus.quotient), 32'h0);
        check("reset_remainder", 32'(bus.remainder), 32'h0);
        check("reset_div_by_zero", 32'(bus.div_by_zero), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
        reset = 1'b1;
        @(negedge clk);

        // Consecutive calls launch in the previous DONE cycle (back-to-back).
        run_op("t1_100_div_7",      8'h64, 8'h07, 1'b1, 8'h0E, 8'h02, 1'b0, 10, 0);
        run_op("t2_m7_div_2",       8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 10, 0);
        run_op("t2_7_div_m2",       8'h07, 8'hFE, 1'b1, 8'hFD, 8'h01, 1'b0, 10, 0);
        run_op("t3_5_div_0",        8'h05, 8'h00, 1'b1, 8'hFF, 8'h05, 1'b1, 1,  0);
        run_op("t4_m128_div_m1",    8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 10, 0);
        run_op("t4_m128_div_m128",  8'h80, 8'h80, 1'b1, 8'h01, 8'h00, 1'b0, 10, 0);
        run_op("t4_127_div_m128",   8'h7F, 8'h80, 1'b1, 8'h00, 8'h7F, 1'b0, 10, 0);
        run_op("t5_ignore_start",   8'h64, 8'h07, 1'b1, 8'h0E, 8'h02, 1'b0, 10, 3);
        repeat (3) @(negedge clk);

        // Abort mid-operation: nothing is queued, so any later DONE is flagged by the monitor.
        bus.start    = 1'b1;
        bus.dividend = 8'h64;
        bus.divisor  = 8'h07;
        repeat (4) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        check("t5_busy_before_reset", 32'(bus.busy), 32'h1);
        reset = 1'b0;
        @(negedge clk);
        check("t5_abort_busy", 32'(bus.busy), 32'h0);
        check("t5_abort_done", 32'(bus.done), 32'h0);
        check("t5_abort_quotient", 32'(bus.quotient), 32'h0);
        check("t5_abort_remainder", 32'(bus.remainder), 32'h0);
        check("t5_abort_div_by_zero", 32'(bus.div_by_zero), 32'h0);
        reset = 1'b1;
        repeat (15) @(negedge clk);

`ifdef ALU_DIV_UNSIGNED_EN
        run_op("t6_unsigned",       8'hF9, 8'h02, 1'b0, 8'h7C, 8'h01, 1'b0, 10, 0);
        run_op("t6_signed",         8'hF9, 8'h02, 1'b1, 8'hFD, 8'hFF, 1'b0, 10, 0);
        run_op("t6_unsigned_div0",  8'h05, 8'h00, 1'b0, 8'hFF, 8'h05, 1'b1, 1,  0);
        repeat (2) @(negedge clk);
`endif

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL pending_results: got %0d outstanding required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
